// File: rtl/pulse_stretch_pkg.sv
// Shared types and default sizes for the multi-channel pulse stretcher.
package pulse_stretch_pkg;

  localparam int DEF_WIDTH = 48;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_stretch_chan.sv
// One channel of the pulse stretcher: edge detect, IDLE/ACTIVE/DEAD sequencing
// with a shared width/dead-time counter, and a sticky lost-edge flag.
module pulse_stretch_chan
  import pulse_stretch_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in_i,
  input  logic             chan_en_i,
  input  logic [CNT_W-1:0] stretch_len_i,
  input  logic [CNT_W-1:0] dead_len_i,
  input  logic             retrig_en_i,
  input  logic             clr_lost_i,
  output logic             sig_out_o,
  output logic             busy_o,
  output logic             lost_edge_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sig_d_q;
  logic             arm_q, arm_d;
  logic             sig_out_q, busy_q;
  logic             lost_q, lost_d;
  logic             lost_set;
  logic             edge_det;
  logic             trig;

  function automatic logic [CNT_W-1:0] load_len(input logic [CNT_W-1:0] len);
    return (len == CNT_ZERO) ? CNT_ONE : len;
  endfunction

  // arm_q stays low until sig_in has been seen low after reset, so a level
  // held high across reset release is not mistaken for a rising edge.
  assign arm_d    = arm_q | ~sig_in_i;
  assign edge_det = sig_in_i & ~sig_d_q & arm_q;
  assign trig     = edge_det & chan_en_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lost_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_ACTIVE;
          cnt_d   = load_len(stretch_len_i);
        end
      end
      ST_ACTIVE: begin
        if (trig && retrig_en_i) begin
          cnt_d = load_len(stretch_len_i);
        end else begin
          lost_set = trig;
          if (cnt_q <= CNT_ONE) begin
            if (dead_len_i == CNT_ZERO) begin
              state_d = ST_IDLE;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = ST_DEAD;
              cnt_d   = dead_len_i;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_DEAD: begin
        // Edges here, including the expiry cycle, are discarded and counted as lost.
        lost_set = trig;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_comb begin
    lost_d = lost_q;
    if (lost_set) begin
      lost_d = 1'b1;
    end else if (clr_lost_i) begin
      lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      sig_d_q   <= 1'b0;
      arm_q     <= 1'b0;
      sig_out_q <= 1'b0;
      busy_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sig_d_q   <= sig_in_i;
      arm_q     <= arm_d;
      sig_out_q <= (state_d == ST_ACTIVE);
      busy_q    <= (state_d != ST_IDLE);
      lost_q    <= lost_d;
    end
  end

  assign sig_out_o   = sig_out_q;
  assign busy_o      = busy_q;
  assign lost_edge_o = lost_q;

endmodule

// File: rtl/pulse_stretch_multi.sv
// WIDTH independent pulse stretchers sharing length, dead-time and mode controls.
module pulse_stretch_multi
  import pulse_stretch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sig_in,
  input  logic [WIDTH-1:0] chan_en,
  input  logic [CNT_W-1:0] stretch_len,
  input  logic [CNT_W-1:0] dead_len,
  input  logic             retrig_en,
  input  logic             clr_lost,
  output logic [WIDTH-1:0] sig_out,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] lost_edge
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      pulse_stretch_chan #(
        .CNT_W(CNT_W)
      ) u_chan (
        .clk          (clk),
        .rst_n        (rst_n),
        .sig_in_i     (sig_in[gi]),
        .chan_en_i    (chan_en[gi]),
        .stretch_len_i(stretch_len),
        .dead_len_i   (dead_len),
        .retrig_en_i  (retrig_en),
        .clr_lost_i   (clr_lost),
        .sig_out_o    (sig_out[gi]),
        .busy_o       (busy[gi]),
        .lost_edge_o  (lost_edge[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Bench for pulse_stretch_multi: directed table on channel 0, reset and
// all-channel sequences, then random traffic against a timeline model.
module tb_pulse_stretch_multi;

  localparam int W  = 48;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  sig_in, chan_en;
  logic [CW-1:0] stretch_len, dead_len;
  logic          retrig_en, clr_lost;
  logic [W-1:0]  sig_out, busy, lost_edge;

  pulse_stretch_multi #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .chan_en(chan_en),
    .stretch_len(stretch_len), .dead_len(dead_len), .retrig_en(retrig_en),
    .clr_lost(clr_lost), .sig_out(sig_out), .busy(busy), .lost_edge(lost_edge)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  // Timeline model: per channel, last cycle the output is high and last dead cycle.
  int       m_out_end [W];
  int       m_dead_end[W];
  bit       m_prev    [W];
  bit       m_lost    [W];
  logic [W-1:0] exp_out, exp_busy, exp_lost;

  typedef struct {
    logic          s;
    logic [CW-1:0] sl;
    logic [CW-1:0] dl;
    logic          rt;
    logic          clr;
    logic          eo;
    logic          eb;
    logic          el;
  } vec_t;

  vec_t tbl[29];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int eff_len(input logic [CW-1:0] l);
    return (l == 0) ? 1 : int'(l);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < W; c++) begin
      m_out_end[c]  = -1;
      m_dead_end[c] = -1;
      m_prev[c]     = 1'b1;
      m_lost[c]     = 1'b0;
    end
    exp_out  = '0;
    exp_busy = '0;
    exp_lost = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < W; c++) begin
      bit e;
      bit set;
      e   = sig_in[c] && !m_prev[c] && chan_en[c];
      set = 1'b0;
      m_prev[c] = sig_in[c];
      if (cyc <= m_out_end[c]) begin
        if (e) begin
          if (retrig_en) m_out_end[c] = cyc + eff_len(stretch_len);
          else set = 1'b1;
        end
        if (cyc == m_out_end[c]) m_dead_end[c] = cyc + int'(dead_len);
      end else if (cyc <= m_dead_end[c]) begin
        if (e) set = 1'b1;
      end else if (e) begin
        m_out_end[c] = cyc + eff_len(stretch_len);
      end
      if (set) m_lost[c] = 1'b1;
      else if (clr_lost) m_lost[c] = 1'b0;
      exp_out[c]  = (cyc + 1 <= m_out_end[c]);
      exp_busy[c] = exp_out[c] || (cyc + 1 <= m_dead_end[c]);
      exp_lost[c] = m_lost[c];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("model_sig_out", sig_out, exp_out);
    chk("model_busy", busy, exp_busy);
    chk("model_lost_edge", lost_edge, exp_lost);
  endtask

  initial begin
    logic [63:0] r;
    rst_n = 1'b0; sig_in = '0; chan_en = '1;
    stretch_len = 8'd4; dead_len = 8'd0; retrig_en = 1'b0; clr_lost = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_sig_out", sig_out, '0);
    chk("reset_busy", busy, '0);
    chk("reset_lost", lost_edge, '0);
    rst_n = 1'b1;

    //          s   sl  dl  rt  clr  eo  eb  el
    tbl[0]  = '{0, 4, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 4, 0, 0, 0, 1, 1, 0};
    tbl[2]  = '{0, 4, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{0, 4, 0, 0, 0, 1, 1, 0};
    tbl[4]  = '{0, 4, 0, 0, 0, 1, 1, 0};
    tbl[5]  = '{0, 4, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 3, 2, 0, 0, 1, 1, 0};
    tbl[7]  = '{0, 3, 2, 0, 0, 1, 1, 0};
    tbl[8]  = '{1, 3, 2, 0, 0, 1, 1, 1};
    tbl[9]  = '{0, 3, 2, 0, 0, 0, 1, 1};
    tbl[10] = '{0, 3, 2, 0, 0, 0, 1, 1};
    tbl[11] = '{1, 3, 2, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 3, 2, 0, 0, 0, 0, 1};
    tbl[13] = '{0, 3, 2, 0, 1, 0, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 1, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 4, 0, 1, 0, 1, 1, 0};
    tbl[17] = '{0, 4, 0, 1, 0, 1, 1, 0};
    tbl[18] = '{1, 4, 0, 1, 0, 1, 1, 0};
    tbl[19] = '{0, 4, 0, 1, 0, 1, 1, 0};
    tbl[20] = '{0, 4, 0, 1, 0, 1, 1, 0};
    tbl[21] = '{0, 4, 0, 1, 0, 1, 1, 0};
    tbl[22] = '{0, 4, 0, 1, 0, 0, 0, 0};
    tbl[23] = '{1, 4, 0, 0, 0, 1, 1, 0};
    tbl[24] = '{0, 4, 0, 0, 0, 1, 1, 0};
    tbl[25] = '{1, 4, 0, 0, 1, 1, 1, 1};
    tbl[26] = '{0, 4, 0, 0, 0, 1, 1, 1};
    tbl[27] = '{0, 4, 0, 0, 0, 0, 0, 1};
    tbl[28] = '{0, 4, 0, 0, 1, 0, 0, 0};

    for (int i = 0; i < 29; i++) begin
      sig_in = {{(W-1){1'b0}}, tbl[i].s};
      stretch_len = tbl[i].sl; dead_len = tbl[i].dl;
      retrig_en = tbl[i].rt; clr_lost = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_sig_out0", i), {{(W-1){1'b0}}, sig_out[0]}, {{(W-1){1'b0}}, tbl[i].eo});
      chk($sformatf("tbl%0d_busy0", i), {{(W-1){1'b0}}, busy[0]}, {{(W-1){1'b0}}, tbl[i].eb});
      chk($sformatf("tbl%0d_lost0", i), {{(W-1){1'b0}}, lost_edge[0]}, {{(W-1){1'b0}}, tbl[i].el});
      chk($sformatf("tbl%0d_others_out", i), sig_out & ~{{(W-1){1'b0}}, 1'b1}, '0);
    end
    clr_lost = 1'b0;

    // Reset mid-pulse, with inputs held high across release.
    stretch_len = 8'd8; dead_len = 8'd0; retrig_en = 1'b0;
    sig_in = '0; tick();
    sig_in = '1; tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sig_out", sig_out, '0);
    chk("rst_mid_busy", busy, '0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("held_high_no_pulse", sig_out, '0);
    sig_in = '0; tick();
    sig_in = '1; tick();
    chk("toggle_after_reset", sig_out, '1);

    // All channels rising together with the upper 16 disabled.
    sig_in = '0; chan_en = 48'h0000_FFFF_FFFF; stretch_len = 8'd3;
    for (int i = 0; i < 12; i++) tick();
    sig_in = '1; tick();
    chk("all_ch_sig_out", sig_out, 48'h0000_FFFF_FFFF);
    chk("all_ch_lost", lost_edge, '0);
    sig_in = '0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) begin
        stretch_len = CW'($urandom_range(0, 6));
        dead_len    = CW'($urandom_range(0, 4));
        retrig_en   = 1'($urandom_range(0, 1));
      end
      r = {$urandom, $urandom};
      sig_in = r[W-1:0];
      r = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      chan_en = r[W-1:0];
      clr_lost = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_stretch_multi.md
PULSE_STRETCH_MULTI -- requirements
Module: pulse_stretch_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 48: number of independent channels.
REQ-002 SHALL have parameter CNT_W, default 8: width of the length and dead-time counters.
REQ-003 SHALL have port clk, input, 1: single system clock (200 MHz nominal); all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port sig_in, input, WIDTH: raw discriminator pulses, one per channel, synchronous to clk.
REQ-006 SHALL have port chan_en, input, WIDTH: per-channel enable; a disabled channel ignores edges.
REQ-007 SHALL have port stretch_len, input, CNT_W: output pulse width in clk cycles, shared by all channels.
REQ-008 SHALL have port dead_len, input, CNT_W: dead time in clk cycles after each output pulse.
REQ-009 SHALL have port retrig_en, input, 1: retrigger mode; 1 = an edge during an active pulse restarts the width count.
REQ-010 SHALL have port clr_lost, input, 1: one-cycle strobe that clears lost_edge.
REQ-011 SHALL have port sig_out, output, WIDTH: stretched pulses.
REQ-012 SHALL have port busy, output, WIDTH: channel is in ACTIVE or DEAD.
REQ-013 SHALL have port lost_edge, output, WIDTH: sticky flag, an edge was discarded.

Function
REQ-014 Each channel SHALL register sig_in once (sig_d); an edge is defined as sig_in & ~sig_d in the current cycle.
REQ-015 Each channel SHALL implement an FSM with states IDLE, ACTIVE and DEAD.
REQ-016 IDLE: an edge with chan_en=1 in cycle t SHALL move the FSM to ACTIVE, load the counter with max(stretch_len,1), and drive sig_out=1 from cycle t+1.
REQ-017 ACTIVE: sig_out SHALL be 1 for exactly the loaded count of cycles; the counter decrements each cycle.
REQ-018 ACTIVE, retrig_en=1: an edge SHALL reload the counter so that sig_out stays high for max(stretch_len,1) cycles after the cycle following that edge, with no low gap.
REQ-019 ACTIVE, retrig_en=0: an edge SHALL be ignored and SHALL set lost_edge for that channel.
REQ-020 On ACTIVE expiry the FSM SHALL enter DEAD with the counter = dead_len, or go directly to IDLE if dead_len=0; sig_out SHALL be 0 in DEAD.
REQ-021 DEAD: an edge SHALL be ignored and SHALL set lost_edge; on expiry the FSM returns to IDLE, and an edge arriving in the expiry cycle SHALL be discarded.
REQ-022 stretch_len and dead_len SHALL be sampled only when the counter loads; changes mid-pulse SHALL NOT affect the running count.
REQ-023 chan_en=0 SHALL NOT abort a pulse already in progress; it only blocks new triggers and retriggers, and blocked edges SHALL NOT set lost_edge.
REQ-024 If clr_lost and a new loss occur in the same cycle, the set SHALL win.
REQ-025 busy SHALL be 1 whenever the FSM is not IDLE; sig_out and busy SHALL be registered outputs.
REQ-026 Channels SHALL be fully independent; simultaneous edges on all WIDTH channels SHALL be handled in the same cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force every FSM to IDLE, and all counters, sig_d, sig_out, busy and lost_edge to 0.
REQ-028 Reset asserted mid-pulse SHALL drop sig_out within the same cycle; after release, the first edge SHALL require sig_in low-to-high, with sig_d=0 at release.

Structure
REQ-029 A shared package pulse_stretch_pkg SHALL hold the state enum (IDLE/ACTIVE/DEAD) and the default WIDTH/CNT_W constants.
REQ-030 The per-channel logic SHALL live in sub-module pulse_stretch_chan (parameter CNT_W), instantiated WIDTH times by a generate loop; the top holds no per-channel state.

Verification
REQ-031 Single pulse: stretch_len=4, dead_len=0, 1-cycle pulse on ch0 at t -> sig_out[0] high t+1..t+4, busy matches, other channels stay 0.
REQ-032 Retrigger: stretch_len=4, retrig_en=1, edges at t and t+2 -> sig_out high t+1..t+6 continuously, lost_edge=0.
REQ-033 No retrigger plus dead time: stretch_len=3, dead_len=2, retrig_en=0, edges at t, t+2, t+5 -> sig_out high t+1..t+3 only, and lost_edge[ch] set by t+3.
REQ-034 Boundary: stretch_len=0 gives a 1-cycle output; an edge in the DEAD expiry cycle is dropped; clr_lost coinciding with a loss leaves lost_edge=1.
REQ-035 Reset mid-pulse: rst_n low during ACTIVE -> sig_out/busy 0 immediately; sig_in held high across release produces no pulse until it toggles.
REQ-036 All channels: WIDTH=48, all sig_in rising together with chan_en=0x0000_FFFF_FFFF -> only channels 0..31 stretch, and lost_edge stays 0.
